// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the fetch PC sequencer.
package pc_seq_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_VEC = 32'h0000_3000;
  localparam logic [XLEN-1:0] PC_EXC_VEC   = 32'h0000_4180;

  typedef enum logic {
    RUN,
    PEND
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_ERET,
    SRC_EXC
  } src_e;

  // Branch target: PC+4 of the branch plus the word offset, mod 2^32.
  function automatic logic [XLEN-1:0] br_target(input logic [XLEN-1:0] npc,
                                                input logic [XLEN-1:0] off);
    return npc + (off << 2);
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Redirect target computation and priority select for the fetch PC.
module pc_target_mux
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VEC = PC_EXC_VEC
) (
  input  logic [XLEN-1:0] id_npc_i,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_offset_i,
  input  logic            j_valid_i,
  input  logic [25:0]     j_index_i,
  input  logic            jr_valid_i,
  input  logic [XLEN-1:0] jr_target_i,
  input  logic            exc_req_i,
  input  logic            eret_req_i,
  input  logic [XLEN-1:0] epc_i,
  output logic [XLEN-1:0] tgt_o,
  output src_e            src_o,
  output logic            misalign_o
);

  // Fixed priority: exception, ERET, JR, J, taken branch, sequential.
  always_comb begin
    src_o = SRC_SEQ;
    tgt_o = '0;
    if (exc_req_i) begin
      src_o = SRC_EXC;
      tgt_o = EXC_VEC;
    end else if (eret_req_i) begin
      src_o = SRC_ERET;
      tgt_o = epc_i;
    end else if (jr_valid_i) begin
      src_o = SRC_JR;
      tgt_o = jr_target_i;
    end else if (j_valid_i) begin
      src_o = SRC_J;
      tgt_o = {id_npc_i[31:28], j_index_i, 2'b00};
    end else if (br_valid_i && br_taken_i) begin
      src_o = SRC_BR;
      tgt_o = br_target(id_npc_i, br_offset_i);
    end
  end

  // Only register-sourced targets can be misaligned.
  assign misalign_o = ((src_o == SRC_JR) || (src_o == SRC_ERET)) && (tgt_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with redirect select, stall-time redirect holding and stats.
// Define PC_DELAY_SLOT_EN for delay-slot semantics (no IF flush on branch/jump/ERET).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = PC_RESET_VEC,
  parameter logic [XLEN-1:0] EXC_VEC   = PC_EXC_VEC,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [XLEN-1:0]  id_npc,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_offset,
  input  logic             j_valid,
  input  logic [25:0]      j_index,
  input  logic             jr_valid,
  input  logic [XLEN-1:0]  jr_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [XLEN-1:0]  epc,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  npc,
  output logic             flush_if,
  output logic             addr_err,
  output logic [CNT_W-1:0] redir_cnt
);

`ifdef PC_DELAY_SLOT_EN
  localparam logic REDIR_FLUSH = 1'b0;
`else
  localparam logic REDIR_FLUSH = 1'b1;
`endif

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              addr_err_q, addr_err_d;
  logic              cnt_inc;
  logic              take_exc;

  logic [XLEN-1:0]   mux_tgt;
  src_e              mux_src;
  logic              mux_misalign;

  pc_target_mux #(
    .EXC_VEC (EXC_VEC)
  ) u_mux (
    .id_npc_i    (id_npc),
    .br_valid_i  (br_valid),
    .br_taken_i  (br_taken),
    .br_offset_i (br_offset),
    .j_valid_i   (j_valid),
    .j_index_i   (j_index),
    .jr_valid_i  (jr_valid),
    .jr_target_i (jr_target),
    .exc_req_i   (exc_req),
    .eret_req_i  (eret_req),
    .epc_i       (epc),
    .tgt_o       (mux_tgt),
    .src_o       (mux_src),
    .misalign_o  (mux_misalign)
  );

  // A misaligned JR/ERET target only matters while new redirects are accepted.
  assign take_exc = (mux_src == SRC_EXC) || ((state_q == RUN) && mux_misalign);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    addr_err_d = 1'b0;
    flush_if   = 1'b0;
    cnt_inc    = 1'b0;

    if (take_exc) begin
      pc_d       = EXC_VEC;
      pend_d     = '0;
      state_d    = RUN;
      flush_if   = 1'b1;
      addr_err_d = (mux_src != SRC_EXC);
    end else begin
      case (state_q)
        RUN: begin
          if (mux_src != SRC_SEQ) begin
            if (stall) begin
              pend_d  = mux_tgt;
              state_d = PEND;
            end else begin
              pc_d     = mux_tgt;
              flush_if = REDIR_FLUSH;
              cnt_inc  = 1'b1;
            end
          end else if (!stall) begin
            pc_d = pc_q + 32'd4;
          end
        end
        PEND: begin
          // First latched redirect wins; later ID inputs are ignored.
          if (!stall) begin
            pc_d     = pend_q;
            pend_d   = '0;
            flush_if = REDIR_FLUSH;
            cnt_inc  = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_VEC;
      pend_q     <= '0;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc        = pc_q;
  assign npc       = pc_q + 32'd4;
  assign addr_err  = addr_err_q;
  assign redir_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a behavioural model of the fetch PC.
module tb_pc_sequencer;

  localparam int unsigned TB_CNT_W = 4;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam logic [31:0] RST_V    = 32'h0000_3000;
  localparam logic [31:0] EXC_V    = 32'h0000_4180;
`ifdef PC_DELAY_SLOT_EN
  localparam bit EXP_REDIR_FLUSH = 1'b0;
`else
  localparam bit EXP_REDIR_FLUSH = 1'b1;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                stall;
  logic [31:0]         id_npc;
  logic                br_valid, br_taken;
  logic [31:0]         br_offset;
  logic                j_valid;
  logic [25:0]         j_index;
  logic                jr_valid;
  logic [31:0]         jr_target;
  logic                exc_req, eret_req;
  logic [31:0]         epc;
  logic [31:0]         pc, npc;
  logic                flush_if, addr_err;
  logic [TB_CNT_W-1:0] redir_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pend_tgt;
  bit          m_pend;
  int          m_cnt;
  bit          m_addr_err;

  always #5 clk = ~clk;

  pc_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .id_npc    (id_npc),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .j_valid   (j_valid),
    .j_index   (j_index),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .pc        (pc),
    .npc       (npc),
    .flush_if  (flush_if),
    .addr_err  (addr_err),
    .redir_cnt (redir_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    stall = 0; id_npc = '0; br_valid = 0; br_taken = 0; br_offset = '0;
    j_valid = 0; j_index = '0; jr_valid = 0; jr_target = '0;
    exc_req = 0; eret_req = 0; epc = '0;
  endtask

  task automatic model_reset();
    m_pc = RST_V; m_pend = 0; m_pend_tgt = '0; m_cnt = 0; m_addr_err = 0;
  endtask

  // Entered at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    logic [31:0] tgt, nxt;
    bit has_tgt, aerr_e, flush_e, inc;
    #1;
    aerr_e = 0;
    if (!exc_req && !m_pend) begin
      if (eret_req)      aerr_e = (epc[1:0] != 2'b00);
      else if (jr_valid) aerr_e = (jr_target[1:0] != 2'b00);
    end
    has_tgt = 1;
    tgt     = '0;
    if (eret_req)                  tgt = epc;
    else if (jr_valid)             tgt = jr_target;
    else if (j_valid)              tgt = {id_npc[31:28], j_index, 2'b00};
    else if (br_valid && br_taken) tgt = id_npc + {br_offset[29:0], 2'b00};
    else                           has_tgt = 0;

    flush_e = 0; inc = 0; nxt = m_pc;
    if (exc_req || aerr_e) begin
      nxt = EXC_V; flush_e = 1; m_pend = 0;
    end else if (m_pend) begin
      if (!stall) begin nxt = m_pend_tgt; flush_e = EXP_REDIR_FLUSH; inc = 1; m_pend = 0; end
    end else if (has_tgt) begin
      if (!stall) begin nxt = tgt; flush_e = EXP_REDIR_FLUSH; inc = 1; end
      else begin m_pend = 1; m_pend_tgt = tgt; end
    end else if (!stall) begin
      nxt = m_pc + 32'd4;
    end

    check_eq("flush_if", 32'(flush_if), 32'(flush_e));
    check_eq("npc", npc, m_pc + 32'd4);
    @(posedge clk);
    #1;
    m_pc = nxt;
    if (inc && m_cnt < CNT_MAX) m_cnt++;
    m_addr_err = aerr_e;
    check_eq("pc", pc, m_pc);
    check_eq("addr_err", 32'(addr_err), 32'(m_addr_err));
    check_eq("redir_cnt", 32'(redir_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    #1;
    model_reset();
    check_eq("rst_pc", pc, RST_V);
    check_eq("rst_cnt", 32'(redir_cnt), 32'd0);
    check_eq("rst_addr_err", 32'(addr_err), 32'd0);
    check_eq("rst_flush", 32'(flush_if), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic set_branch();
    set_idle();
    id_npc = 32'h0000_3010; br_valid = 1; br_taken = 1; br_offset = 32'hFFFF_FFFC;
  endtask

  initial begin
    reset = 0;
    set_idle();
    #2;
    do_reset();

    // Free-running sequential fetch
    for (int i = 0; i < 3; i++) step();
    check_eq("t1_pc", pc, 32'h0000_300C);

    // Unstalled taken branch
    set_branch();
    step();
    check_eq("t2_pc", pc, 32'h0000_3000);
    check_eq("t2_cnt", 32'(redir_cnt), 32'd1);

    // Branch held across a 3-cycle stall; later inputs ignored
    set_branch(); stall = 1;
    for (int i = 0; i < 3; i++) step();
    check_eq("t3_frozen", pc, 32'h0000_3000);
    set_idle(); j_valid = 1; j_index = 26'h155; id_npc = 32'h0000_3010;
    step();
    check_eq("t3_pc", pc, 32'h0000_3000);
    check_eq("t3_cnt", 32'(redir_cnt), 32'd2);

    // Misaligned JR becomes an exception
    set_idle(); jr_valid = 1; jr_target = 32'h0000_3022;
    step();
    check_eq("t4_pc", pc, EXC_V);
    check_eq("t4_addr_err", 32'(addr_err), 32'd1);
    set_idle();
    step();
    check_eq("t4_pulse_end", 32'(addr_err), 32'd0);

    // Exception under stall discards a pending redirect
    set_branch(); stall = 1;
    step();
    set_idle(); stall = 1; exc_req = 1; j_valid = 1; j_index = 26'h3;
    step();
    check_eq("t5_pc", pc, EXC_V);
    set_idle();
    step();
    check_eq("t5_no_pend", pc, EXC_V + 32'd4);

    // Asynchronous reset in the middle of a PEND cycle
    set_branch(); stall = 1;
    step();
    #2;
    reset = 1;
    #1;
    check_eq("t6_async_pc", pc, RST_V);
    check_eq("t6_async_cnt", 32'(redir_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    set_idle();
    step();
    check_eq("t6_run", pc, RST_V + 32'd4);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        stall     = ($urandom_range(0, 99) < 35);
        id_npc    = {$urandom(), 2'b00} >> 0;
        id_npc[1:0] = 2'b00;
        br_valid  = ($urandom_range(0, 99) < 30);
        br_taken  = $urandom_range(0, 1) == 1;
        br_offset = 32'($signed($urandom_range(0, 65535) - 32768));
        j_valid   = ($urandom_range(0, 99) < 10);
        j_index   = 26'($urandom());
        jr_valid  = ($urandom_range(0, 99) < 10);
        jr_target = $urandom();
        if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
        eret_req  = ($urandom_range(0, 99) < 5);
        epc       = $urandom();
        if ($urandom_range(0, 3) != 0) epc[1:0] = 2'b00;
        exc_req   = ($urandom_range(0, 99) < 4);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch PC register of the MIPS pipeline.
- Each cycle it picks the next PC from five sources: sequential, conditional branch, J/JAL, JR/JALR, exception/ERET.
- It computes the branch target as id_npc + (offset << 2), drives the IF-stage kill signal, and holds redirects that arrive during stalls until the stall clears.
- It sits between the ID-stage branch/jump resolution logic and instruction memory.

Parameters:
- RESET_VEC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry.
- CNT_W, 16, width of the taken-redirect statistics counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit freeze; PC holds
- id_npc  in  32  PC+4 of the instruction in ID
- br_valid  in  1  ID holds a conditional branch
- br_taken  in  1  branch condition true; qualified by br_valid
- br_offset  in  32  sign-extended 16-bit immediate
- j_valid  in  1  ID holds J/JAL
- j_index  in  26  instr_index field
- jr_valid  in  1  ID holds JR/JALR
- jr_target  in  32  register target
- exc_req  in  1  exception request
- eret_req  in  1  ERET in ID
- epc  in  32  return address for ERET
- pc  out  32  current fetch address
- npc  out  32  pc + 4, combinational from pc
- flush_if  out  1  kill the instruction currently in IF
- addr_err  out  1  one-cycle pulse: misaligned redirect target
- redir_cnt  out  CNT_W  count of taken redirects

Behaviour:
- Reset (async, wins over everything):
  - pc = RESET_VEC, state = RUN, flush_if = 0, addr_err = 0, redir_cnt = 0, pending target cleared.
- Targets, all arithmetic mod 2^32:
  - br_tgt = id_npc + {br_offset[29:0], 2'b00}
  - j_tgt = {id_npc[31:28], j_index, 2'b00}
  - jr_tgt = jr_target
- Source priority: exc_req > eret_req > jr_valid > j_valid > (br_valid & br_taken) > sequential.
- Misaligned target:
  - Condition: the selected JR or ERET target has bits [1:0] != 0.
  - Action: treated as an exception. pc <= EXC_VEC, addr_err pulses for 1 cycle.
- FSM states: RUN, PEND.
- RUN, stall = 0:
  - Redirect selected: pc <= target at the next edge. flush_if = 1 combinationally in the same cycle. redir_cnt += 1 (saturating).
  - No redirect: pc <= pc + 4.
- RUN, stall = 1:
  - pc holds.
  - A non-exception redirect latches its target into pend_tgt and moves the FSM to PEND. No flush this cycle.
- PEND:
  - pc holds while stall = 1.
  - New branch/jump inputs are ignored; the first latched redirect wins.
  - When stall = 0: pc <= pend_tgt, flush_if = 1, redir_cnt += 1, go to RUN.
- exc_req in any state, stalled or not:
  - pc <= EXC_VEC next edge, flush_if = 1, any pending target discarded, state = RUN.
- Latency: a redirect becomes visible on pc exactly 1 cycle after it is accepted (unstalled), or 1 cycle after stall falls when it was pending.
- redir_cnt saturates at all-ones.
- flush_if is purely combinational from the current inputs and state; there are no registered glitches.

Optional Feature:
- Macro: PC_DELAY_SLOT_EN.
- Defined:
  - MIPS branch delay slot semantics. flush_if is not asserted for branch, J, JR or ERET redirects; the IF instruction, which is the delay slot, executes.
  - The PEND flush is also suppressed.
  - Exceptions still assert flush_if.
- Undefined: behaviour exactly as above; every taken redirect flushes IF.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum {RUN, PEND}
  - source-select enum {SRC_SEQ, SRC_BR, SRC_J, SRC_JR, SRC_ERET, SRC_EXC}
  - RESET_VEC and EXC_VEC defaults
- Sub-module pc_target_mux:
  - Combinational target computation plus priority select.
  - Outputs the selected target, its source, and the misaligned flag.
- The top level keeps the PC register, FSM, pending register and counter.

Test Plan:
1. Reset then 3 free cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; flush_if = 0.
2. id_npc = 0x3010, br_valid = 1, br_taken = 1, br_offset = 0xFFFF_FFFC -> flush_if = 1 that cycle; next pc = 0x3000; redir_cnt = 1. With PC_DELAY_SLOT_EN: flush_if = 0.
3. Same branch while stall = 1 for 3 cycles -> pc frozen, state PEND; cycle stall falls: flush_if = 1; next pc = 0x3000.
4. jr_valid = 1, jr_target = 0x3022 -> addr_err pulse, pc = 0x4180.
5. exc_req = 1 together with j_valid = 1 and stall = 1 -> pc = 0x4180 next edge, pending discarded, flush_if = 1.
6. Assert reset mid-PEND -> pc = 0x3000 immediately (async), redir_cnt = 0, state RUN.
